// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// Module  : alu_rr_scheduler
// Purpose : Round-robin scheduler sharing one 8-bit Add/Sub/Mul/Div datapath
//           among NUM_REQ requesters. Optional macro ALU_DIV0_ERR_EN adds the
//           Rsp_Err divide-by-zero flag output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_REQ-1:0]   Req_Valid,
    output logic [NUM_REQ-1:0]   Req_Ready,
    input  logic [4*NUM_REQ-1:0] Req_Op,
    input  logic [8*NUM_REQ-1:0] Req_In1,
    input  logic [8*NUM_REQ-1:0] Req_In2,
    output logic                 Rsp_Valid,
    input  logic                 Rsp_Ready,
    output logic [ID_W-1:0]      Rsp_Id,
    output logic [7:0]           Rsp_Out
`ifdef ALU_DIV0_ERR_EN
    ,
    output logic                 Rsp_Err
`endif
);

    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [3:0]      op_q;
    logic [7:0]      in1_q;
    logic [7:0]      in2_q;
    logic [7:0]      result;

    // Lowest valid index overall, overridden by lowest valid index at/above ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req_Valid[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req_Valid[i] && (ID_W'(i) >= ptr)) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        Req_Ready = '0;
        if ((state == IDLE) && found && !Rst) begin
            Req_Ready[winner] = 1'b1;
        end
    end

    always_comb begin
        result = in1_q + in2_q;
        case (op_q)
            OP_SUB:  result = in1_q - in2_q;
            OP_MUL:  result = in1_q * in2_q;
            OP_DIV:  result = (in2_q == 8'h00) ? 8'hFF : (in1_q / in2_q);
            default: result = in1_q + in2_q;
        endcase
    end

`ifdef ALU_DIV0_ERR_EN
    logic div_zero;
    assign div_zero = (op_q == OP_DIV) && (in2_q == 8'h00);
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            Rsp_Valid <= 1'b0;
            Rsp_Id    <= '0;
            Rsp_Out   <= '0;
`ifdef ALU_DIV0_ERR_EN
            Rsp_Err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_q   <= Req_Op[4*winner +: 4];
                        in1_q  <= Req_In1[8*winner +: 8];
                        in2_q  <= Req_In2[8*winner +: 8];
                        Rsp_Id <= winner;
                        ptr    <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    Rsp_Out   <= result;
`ifdef ALU_DIV0_ERR_EN
                    Rsp_Err   <= div_zero;
`endif
                    Rsp_Valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        Rsp_Valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    Rsp_Valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
// ============================================================================
// Module  : tb_alu_rr_scheduler
// Purpose : Directed self-checking bench for alu_rr_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rr_scheduler;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req_Valid;
    logic [3:0]  Req_Ready;
    logic [15:0] Req_Op;
    logic [31:0] Req_In1;
    logic [31:0] Req_In2;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [1:0]  Rsp_Id;
    logic [7:0]  Rsp_Out;
`ifdef ALU_DIV0_ERR_EN
    logic        Rsp_Err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_Op    (Req_Op),
        .Req_In1   (Req_In1),
        .Req_In2   (Req_In2),
        .Rsp_Valid (Rsp_Valid),
        .Rsp_Ready (Rsp_Ready),
        .Rsp_Id    (Rsp_Id),
        .Rsp_Out   (Rsp_Out)
`ifdef ALU_DIV0_ERR_EN
        ,
        .Rsp_Err   (Rsp_Err)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [3:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        Req_Valid[id]      = 1'b1;
        Req_Op[id*4 +: 4]  = op;
        Req_In1[id*8 +: 8] = a;
        Req_In2[id*8 +: 8] = b;
    endtask

    task automatic test_reset;
        Rst       = 1'b1;
        Req_Valid = 4'b0101;
        Rsp_Ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (Req_Ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want %b", Req_Ready, 4'b0000); end
        n_cmp++; if (Rsp_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", Rsp_Valid); end
        n_cmp++; if (Rsp_Id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", Rsp_Id); end
        n_cmp++; if (Rsp_Out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", Rsp_Out); end
        Req_Valid = 4'b0000;
        @(negedge Clk);
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add;
        drive_req(0, 4'b0001, 8'h03, 8'h09);
        #1;
        n_cmp++; if (Req_Ready !== 4'b0001) begin n_bad++; $display("FAIL add_grant: got %b want 0001", Req_Ready); end
        tick();
        Req_Valid[0] = 1'b0;
        #1;
        n_cmp++; if (Req_Ready !== 4'b0000) begin n_bad++; $display("FAIL add_exec_ready: got %b want 0000", Req_Ready); end
        n_cmp++; if (Rsp_Valid !== 1'b0) begin n_bad++; $display("FAIL add_exec_valid: got %b want 0", Rsp_Valid); end
        tick();
        n_cmp++; if (Rsp_Valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", Rsp_Valid); end
        n_cmp++; if (Rsp_Id !== 2'd0) begin n_bad++; $display("FAIL add_id: got %0d want 0", Rsp_Id); end
        n_cmp++; if (Rsp_Out !== 8'h0C) begin n_bad++; $display("FAIL add_out: got %h want 0c", Rsp_Out); end
        tick();
        n_cmp++; if (Rsp_Valid !== 1'b0) begin n_bad++; $display("FAIL add_drop: got %b want 0", Rsp_Valid); end
        n_cmp++; if (Rsp_Out !== 8'h0C) begin n_bad++; $display("FAIL add_hold: got %h want 0c", Rsp_Out); end
    endtask

    task automatic test_arith;
        logic [3:0] ops [0:6] = '{4'b0010, 4'b0011, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b1111};
        logic [7:0] va  [0:6] = '{8'h01, 8'h10, 8'h01, 8'd100, 8'h05, 8'hFF, 8'h03};
        logic [7:0] vb  [0:6] = '{8'h02, 8'h11, 8'h01, 8'd7,   8'h00, 8'h02, 8'h04};
        logic [7:0] exp [0:6] = '{8'hFF, 8'h10, 8'h02, 8'd14,  8'hFF, 8'h01, 8'h07};
        Rsp_Ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_req(0, ops[k], va[k], vb[k]);
            #1;
            n_cmp++; if (Req_Ready !== 4'b0001) begin n_bad++; $display("FAIL arith%0d_grant: got %b want 0001", k, Req_Ready); end
            tick();
            Req_Valid[0] = 1'b0;
            tick();
            n_cmp++; if (Rsp_Valid !== 1'b1) begin n_bad++; $display("FAIL arith%0d_valid: got %b want 1", k, Rsp_Valid); end
            n_cmp++; if (Rsp_Out !== exp[k]) begin n_bad++; $display("FAIL arith%0d_out: got %h want %h", k, Rsp_Out, exp[k]); end
`ifdef ALU_DIV0_ERR_EN
            n_cmp++; if (Rsp_Err !== (k == 4)) begin n_bad++; $display("FAIL arith%0d_err: got %b want %b", k, Rsp_Err, (k == 4)); end
`endif
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] expid;
        Rst = 1'b1;
        #2;
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_req(i, 4'b0001, 8'(i), 8'h10);
        Rsp_Ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            expid = 2'(g % 4);
            n_cmp++; if (Req_Ready !== (4'b0001 << expid)) begin n_bad++; $display("FAIL rr%0d_grant: got %b want %b", g, Req_Ready, 4'b0001 << expid); end
            tick();
            n_cmp++; if (Req_Ready !== 4'b0000) begin n_bad++; $display("FAIL rr%0d_exec_ready: got %b want 0000", g, Req_Ready); end
            tick();
            n_cmp++; if (Req_Ready !== 4'b0000) begin n_bad++; $display("FAIL rr%0d_resp_ready: got %b want 0000", g, Req_Ready); end
            n_cmp++; if (Rsp_Id !== expid) begin n_bad++; $display("FAIL rr%0d_id: got %0d want %0d", g, Rsp_Id, expid); end
            n_cmp++; if (Rsp_Out !== (8'h10 + 8'(expid))) begin n_bad++; $display("FAIL rr%0d_out: got %h want %h", g, Rsp_Out, 8'h10 + 8'(expid)); end
            tick();
        end
        Req_Valid = 4'b0000;
    endtask

    task automatic test_backpressure;
        Rsp_Ready = 1'b0;
        drive_req(0, 4'b0010, 8'h20, 8'h05);
        #1;
        n_cmp++; if (Req_Ready !== 4'b0001) begin n_bad++; $display("FAIL bp_grant0: got %b want 0001", Req_Ready); end
        tick();
        Req_Valid[0] = 1'b0;
        drive_req(1, 4'b0011, 8'h03, 8'h05);
        tick();
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (Rsp_Valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_valid: got %b want 1", c, Rsp_Valid); end
            n_cmp++; if (Rsp_Id !== 2'd0) begin n_bad++; $display("FAIL bp%0d_id: got %0d want 0", c, Rsp_Id); end
            n_cmp++; if (Rsp_Out !== 8'h1B) begin n_bad++; $display("FAIL bp%0d_out: got %h want 1b", c, Rsp_Out); end
            n_cmp++; if (Req_Ready !== 4'b0000) begin n_bad++; $display("FAIL bp%0d_ready: got %b want 0000", c, Req_Ready); end
            tick();
        end
        Rsp_Ready = 1'b1;
        tick();
        n_cmp++; if (Req_Ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant1: got %b want 0010", Req_Ready); end
        tick();
        Req_Valid[1] = 1'b0;
        tick();
        n_cmp++; if (Rsp_Id !== 2'd1) begin n_bad++; $display("FAIL bp_id1: got %0d want 1", Rsp_Id); end
        n_cmp++; if (Rsp_Out !== 8'h0F) begin n_bad++; $display("FAIL bp_out1: got %h want 0f", Rsp_Out); end
        tick();
    endtask

    task automatic test_reset_mid_op;
        // Reset while a response is pending: it must vanish at once.
        Rsp_Ready = 1'b0;
        drive_req(3, 4'b0001, 8'h40, 8'h02);
        #1;
        n_cmp++; if (Req_Ready !== 4'b1000) begin n_bad++; $display("FAIL rmo_grant3: got %b want 1000", Req_Ready); end
        tick();
        Req_Valid[3] = 1'b0;
        tick();
        n_cmp++; if (Rsp_Out !== 8'h42) begin n_bad++; $display("FAIL rmo_out3: got %h want 42", Rsp_Out); end
        #2 Rst = 1'b1;
        #1;
        n_cmp++; if (Rsp_Valid !== 1'b0) begin n_bad++; $display("FAIL rmo_resp_valid: got %b want 0", Rsp_Valid); end
        n_cmp++; if (Rsp_Out !== 8'h00) begin n_bad++; $display("FAIL rmo_resp_out: got %h want 00", Rsp_Out); end
        @(negedge Clk);
        Rst = 1'b0;
        Rsp_Ready = 1'b1;
        drive_req(2, 4'b0100, 8'd100, 8'd7);
        tick();
        Req_Valid[2] = 1'b0;
        #2 Rst = 1'b1;
        #1;
        n_cmp++; if (Rsp_Valid !== 1'b0) begin n_bad++; $display("FAIL rmo_exec_valid: got %b want 0", Rsp_Valid); end
        @(negedge Clk);
        Rst = 1'b0;
        drive_req(0, 4'b0001, 8'h01, 8'h01);
        drive_req(2, 4'b0100, 8'd100, 8'd7);
        #1;
        n_cmp++; if (Req_Ready !== 4'b0001) begin n_bad++; $display("FAIL rmo_first: got %b want 0001", Req_Ready); end
        tick();
        Req_Valid[0] = 1'b0;
        tick();
        n_cmp++; if (Rsp_Id !== 2'd0) begin n_bad++; $display("FAIL rmo_id0: got %0d want 0", Rsp_Id); end
        n_cmp++; if (Rsp_Out !== 8'h02) begin n_bad++; $display("FAIL rmo_out0: got %h want 02", Rsp_Out); end
        tick();
        n_cmp++; if (Req_Ready !== 4'b0100) begin n_bad++; $display("FAIL rmo_second: got %b want 0100", Req_Ready); end
        tick();
        Req_Valid[2] = 1'b0;
        tick();
        n_cmp++; if (Rsp_Id !== 2'd2) begin n_bad++; $display("FAIL rmo_id2: got %0d want 2", Rsp_Id); end
        n_cmp++; if (Rsp_Out !== 8'd14) begin n_bad++; $display("FAIL rmo_out2: got %h want 0e", Rsp_Out); end
        tick();
    endtask

    initial begin
        Rst       = 1'b1;
        Req_Valid = '0;
        Req_Op    = '0;
        Req_In1   = '0;
        Req_In2   = '0;
        Rsp_Ready = 1'b0;
        test_reset();
        test_single_add();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
